// File: rtl/mmio_io_buffer.sv
// Memory-mapped scratch bytes plus a transmit byte FIFO with a status register.
// Reads are combinational; writes, pushes and pops commit on the clock edge; tx stream is valid/ready.
module mmio_io_buffer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WE,
  input  logic [1:0]       size,
  input  logic             uns,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] RData,
  output logic             misalign,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [WIDTH-1:0] TXDATA_ADDR = WIDTH'(DEPTH);
  localparam logic [WIDTH-1:0] STATUS_ADDR = WIDTH'(DEPTH + 4);

  logic [7:0]    scratch  [DEPTH];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic [2:0]    nbytes;
  logic [WIDTH:0] end_addr;
  logic          hit_scratch;
  logic          hit_tx;
  logic          hit_stat;
  logic [AW-1:0] lane_idx [4];
  logic [7:0]    lane_dat [4];
  logic [15:0]   half_dat;
  logic [31:0]   word_dat;
  logic [15:0]   status_word;

  logic          wr_scratch;
  logic          push_req;
  logic          stat_wr;
  logic          full;
  logic          pop;
  logic          push;

  always_comb begin
    case (size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  end

  assign misalign = (size == 2'b11)
                 || (size == 2'b01 && address[0])
                 || (size == 2'b10 && address[1:0] != 2'b00);

  // An access whose last byte lies beyond the scratch region is treated as unmapped.
  assign end_addr    = {1'b0, address} + (WIDTH+1)'(nbytes);
  assign hit_scratch = !misalign && (end_addr <= (WIDTH+1)'(DEPTH));
  assign hit_tx      = !misalign && (address == TXDATA_ADDR);
  assign hit_stat    = !misalign && (address == STATUS_ADDR);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_idx[k] = address[AW-1:0] + AW'(k);
      lane_dat[k] = scratch[lane_idx[k]];
    end
  end

  assign half_dat = {lane_dat[1], lane_dat[0]};
  assign word_dat = {lane_dat[3], lane_dat[2], lane_dat[1], lane_dat[0]};

  assign full = (count == CW'(FIFO_DEPTH));

  always_comb begin
    status_word       = '0;
    status_word[0]    = (count == '0);
    status_word[1]    = full;
    status_word[2]    = overflow;
    status_word[15:8] = 8'(count);
  end

  always_comb begin
    RData = '0;
    if (hit_scratch) begin
      case (size)
        2'b00:   RData = uns ? WIDTH'(lane_dat[0]) : WIDTH'($signed(lane_dat[0]));
        2'b01:   RData = uns ? WIDTH'(half_dat) : WIDTH'($signed(half_dat));
        default: RData = uns ? WIDTH'(word_dat) : WIDTH'($signed(word_dat));
      endcase
    end else if (hit_stat) begin
      RData = WIDTH'(status_word);
    end
  end

  assign wr_scratch = WE && hit_scratch;
  assign push_req   = WE && hit_tx;
  assign stat_wr    = WE && hit_stat;

  assign tx_valid = (count != '0);
  assign tx_data  = fifo_mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) scratch[i] <= 8'(i);
    end else if (wr_scratch) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(nbytes)) scratch[lane_idx[k]] <= WriteData[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) fifo_mem[wr_ptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A dropped push and a clear on the same edge leave overflow set.
      if (push_req && full && !pop)
        overflow <= 1'b1;
      else if (stat_wr && WriteData[2])
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_io_buffer.sv
// Scoreboard bench for mmio_io_buffer: bus reads checked directly, tx bytes checked against a queue.
module tb_mmio_io_buffer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WE = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        uns = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] RData;
  logic        misalign;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  mmio_io_buffer #(.WIDTH(32), .DEPTH(DEPTH), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .WE(WE), .size(size), .uns(uns),
    .address(address), .WriteData(WriteData), .RData(RData), .misalign(misalign),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshake seen at the falling edge commits at the next rising edge.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
      else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic rd_chk(input string tag, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] exp);
    WE = 1'b0; size = sz; uns = u; address = a;
    #1;
    check(tag, RData, exp);
  endtask

  task automatic bus_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    WE = 1'b1; size = sz; uns = 1'b0; address = a; WriteData = d;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic [1:0] sz, input logic accept);
    if (accept) exp_q.push_back(b);
    bus_write(sz, DEPTH, {24'h5A5A5A, b});
  endtask

  task automatic drain(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && tx_valid; i++) begin
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    check(tag, 32'(tx_valid), 32'd0);
    check({tag, "_sb_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    rd_chk("rst_status", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0001);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset pattern and sized reads
    rd_chk("word0", 2'b10, 1'b0, 0, 32'h0302_0100);
    rd_chk("byte5", 2'b00, 1'b0, 5, 32'h0000_0005);
    rd_chk("half1_rdata", 2'b01, 1'b0, 1, 32'h0);
    check("half1_misalign", 32'(misalign), 32'd1);
    rd_chk("word_last", 2'b10, 1'b1, DEPTH - 4, 32'h3F3E_3D3C);
    rd_chk("illegal_size", 2'b11, 1'b1, 0, 32'h0);
    check("illegal_misalign", 32'(misalign), 32'd1);
    bus_write(2'b10, 2, 32'hFFFF_FFFF);
    rd_chk("misal_wr_ignored", 2'b10, 1'b0, 0, 32'h0302_0100);

    // Sized writes and sign/zero extension
    bus_write(2'b10, 8, 32'h80FF_1234);
    rd_chk("byte11_s", 2'b00, 1'b0, 11, 32'hFFFF_FF80);
    rd_chk("half10_u", 2'b01, 1'b1, 10, 32'h0000_80FF);
    rd_chk("half10_s", 2'b01, 1'b0, 10, 32'hFFFF_80FF);
    bus_write(2'b00, 9, 32'h1234_56AA);
    rd_chk("word8_after_byte", 2'b10, 1'b0, 8, 32'h80FF_AA34);
    bus_write(2'b01, 12, 32'hCCCC_BEEF);
    rd_chk("word12_after_half", 2'b10, 1'b0, 12, 32'h0F0E_BEEF);

    // Three pushes, then drain in order
    push(8'h41, 2'b00, 1'b1);
    push(8'h42, 2'b01, 1'b1);
    push(8'h43, 2'b10, 1'b1);
    rd_chk("status_3", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0300);
    check("head_41", 32'(tx_data), 32'h41);
    rd_chk("txdata_reads_0", 2'b10, 1'b0, DEPTH, 32'h0);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("drained3_valid", 32'(tx_valid), 32'd0);
    check("drained3_sb", exp_q.size(), 0);
    rd_chk("status_empty", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0001);

    // Fill, overflow, clear
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i), 2'(i % 3), 1'b1);
    rd_chk("status_full", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0802);
    push(8'h99, 2'b00, 1'b0);
    rd_chk("status_ovf", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0806);
    bus_write(2'b10, DEPTH + 4, 32'hFFFF_FFFB);
    rd_chk("status_noclear", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0806);
    bus_write(2'b00, DEPTH + 4, 32'h0000_0004);
    rd_chk("status_clear", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0802);

    // Push and pop together while full
    tx_ready = 1'b1;
    push(8'h77, 2'b00, 1'b1);
    rd_chk("status_full_pp", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0802);
    drain("drain_full_pp");
    rd_chk("status_after_pp", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0001);

    // Pointer wrap with interleaved pops
    for (int i = 0; i < 20; i++) begin
      tx_ready = (i % 4 != 3);
      push(8'hA0 + 8'(i), 2'(i % 3), 1'b1);
    end
    drain("drain_wrap");
    rd_chk("status_after_wrap", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0001);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 2'b00, 1'b1);
    rd_chk("status_5", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0500);
    reset = 1'b1;
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    rd_chk("midrst_status", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0001);
    rd_chk("midrst_word8", 2'b10, 1'b0, 8, 32'h0B0A_0908);
    rd_chk("midrst_word12", 2'b10, 1'b0, 12, 32'h0F0E_0D0C);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Unmapped address
    bus_write(2'b10, DEPTH + 8, 32'hDEAD_BEEF);
    rd_chk("unmapped_read", 2'b10, 1'b0, DEPTH + 8, 32'h0);
    rd_chk("unmapped_byte", 2'b00, 1'b1, DEPTH + 5, 32'h0);
    rd_chk("unmapped_status", 2'b10, 1'b0, DEPTH + 4, 32'h0000_0001);
    rd_chk("unmapped_word0", 2'b10, 1'b0, 0, 32'h0302_0100);
    check("unmapped_tx_valid", 32'(tx_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
